// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    s_IDLE  = 2'd0,
    s_START = 2'd1,
    s_DATA  = 2'd2,
    s_STOP  = 2'd3
  } t_uart_state;

  localparam logic c_HIGH = 1'b1;
  localparam logic c_LOW  = 1'b0;

  // 50 MHz / 115200 baud
  localparam int c_DEFAULT_CYCLES_PER_BIT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing; o_EXPIRE strobes while enabled at zero.
// Loading N-1 gives an expiry exactly N cycles after the load edge.
module uart_bit_timer #(
  parameter int  c_MAX_CYCLES = 434,
  localparam int c_WIDTH      = $clog2(c_MAX_CYCLES)
) (
  input  logic               i_CLK,
  input  logic               i_RESET_N,
  input  logic               i_ENABLE,
  input  logic               i_LOAD,
  input  logic [c_WIDTH-1:0] i_LOAD_VALUE,
  output logic               o_EXPIRE
);

  logic [c_WIDTH-1:0] count_r;

  // Count register: a load overrides counting, counting stops at zero
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      count_r <= {c_WIDTH{1'b0}};
    end else if (i_LOAD) begin
      count_r <= i_LOAD_VALUE;
    end else if (i_ENABLE && (count_r != {c_WIDTH{1'b0}})) begin
      count_r <= count_r - c_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign o_EXPIRE = i_ENABLE && (count_r == {c_WIDTH{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 frames, LSB first, with a one-byte holding buffer
// behind a valid/ready handshake so the next byte can queue during a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT,
  parameter int c_STOP_BITS      = 1
) (
  input  logic       i_CLK,
  input  logic       i_RESET_N,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_BYTE,
  output logic       o_TX_READY,
  output logic       o_SERIAL_DATA,
  output logic       o_TX_ACTIVE,
  output logic       o_TX_DONE
);

  localparam int c_TMR_W = $clog2(c_CYCLES_PER_BIT * c_STOP_BITS);
  localparam logic [c_TMR_W-1:0] c_BIT_LOAD  = c_TMR_W'(c_CYCLES_PER_BIT - 1);
  localparam logic [c_TMR_W-1:0] c_STOP_LOAD = c_TMR_W'(c_CYCLES_PER_BIT * c_STOP_BITS - 1);

  t_uart_state        state_r, state_s;
  logic               buf_full_r, buf_full_s;
  logic [7:0]         buf_byte_r, buf_byte_s;
  logic               ready_r;
  logic [7:0]         shift_r, shift_s;
  logic [2:0]         bit_idx_r, bit_idx_s;
  logic               serial_r, serial_s;
  logic               active_r, active_s;
  logic               done_r, done_s;
  logic               accept_s, load_s;
  logic               tmr_en_s, tmr_load_s, expire_s;
  logic [c_TMR_W-1:0] tmr_value_s;

  assign accept_s = i_TX_DV && ready_r;
  assign tmr_en_s = (state_r != s_IDLE);

  uart_bit_timer #(
    .c_MAX_CYCLES(c_CYCLES_PER_BIT * c_STOP_BITS)
  ) u_bit_timer (
    .i_CLK       (i_CLK),
    .i_RESET_N   (i_RESET_N),
    .i_ENABLE    (tmr_en_s),
    .i_LOAD      (tmr_load_s),
    .i_LOAD_VALUE(tmr_value_s),
    .o_EXPIRE    (expire_s)
  );

  // Holding buffer: accept and load are exclusive because ready implies empty
  always_comb begin
    buf_full_s = buf_full_r;
    buf_byte_s = buf_byte_r;
    if (accept_s) begin
      buf_full_s = 1'b1;
      buf_byte_s = i_TX_BYTE;
    end else if (load_s) begin
      buf_full_s = 1'b0;
    end else begin
      buf_full_s = buf_full_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_r    <= s_IDLE;
      buf_full_r <= 1'b0;
      buf_byte_r <= 8'h00;
      ready_r    <= 1'b1;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      serial_r   <= c_HIGH;
      active_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      buf_full_r <= buf_full_s;
      buf_byte_r <= buf_byte_s;
      ready_r    <= ~buf_full_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      serial_r   <= serial_s;
      active_r   <= active_s;
      done_r     <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      s_IDLE:  if (buf_full_r) state_s = s_START; else state_s = s_IDLE;
      s_START: if (expire_s) state_s = s_DATA; else state_s = s_START;
      s_DATA:  if (expire_s && (bit_idx_r == 3'd7)) state_s = s_STOP; else state_s = s_DATA;
      s_STOP: begin
        if (expire_s) state_s = buf_full_r ? s_START : s_IDLE;
        else          state_s = s_STOP;
      end
      default: state_s = s_IDLE;
    endcase
  end

  // Output/datapath logic: values the registers take on the coming edge
  always_comb begin
    serial_s    = serial_r;
    active_s    = active_r;
    done_s      = 1'b0;
    load_s      = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_value_s = c_BIT_LOAD;
    shift_s     = shift_r;
    bit_idx_s   = bit_idx_r;
    case (state_r)
      s_IDLE: begin
        serial_s = c_HIGH;
        active_s = 1'b0;
        if (buf_full_r) begin
          load_s     = 1'b1;
          tmr_load_s = 1'b1;
          shift_s    = buf_byte_r;
          bit_idx_s  = 3'd0;
          serial_s   = c_LOW;
          active_s   = 1'b1;
        end else begin
          bit_idx_s = 3'd0;
        end
      end
      s_START: begin
        if (expire_s) begin
          tmr_load_s = 1'b1;
          serial_s   = shift_r[0];
        end else begin
          serial_s = c_LOW;
        end
      end
      s_DATA: begin
        if (expire_s && (bit_idx_r == 3'd7)) begin
          tmr_load_s  = 1'b1;
          tmr_value_s = c_STOP_LOAD;
          serial_s    = c_HIGH;
        end else if (expire_s) begin
          tmr_load_s = 1'b1;
          bit_idx_s  = bit_idx_r + 3'd1;
          shift_s    = {1'b0, shift_r[7:1]};
          serial_s   = shift_r[1];
        end else begin
          serial_s = shift_r[0];
        end
      end
      s_STOP: begin
        if (expire_s && buf_full_r) begin
          // Back-to-back: next start bit begins on the done edge
          done_s     = 1'b1;
          load_s     = 1'b1;
          tmr_load_s = 1'b1;
          shift_s    = buf_byte_r;
          bit_idx_s  = 3'd0;
          serial_s   = c_LOW;
          active_s   = 1'b1;
        end else if (expire_s) begin
          done_s   = 1'b1;
          serial_s = c_HIGH;
          active_s = 1'b0;
        end else begin
          serial_s = c_HIGH;
        end
      end
      default: begin
        serial_s  = c_HIGH;
        active_s  = 1'b0;
        bit_idx_s = 3'd0;
      end
    endcase
  end

  assign o_TX_READY    = ready_r;
  assign o_SERIAL_DATA = serial_r;
  assign o_TX_ACTIVE   = active_r;
  assign o_TX_DONE     = done_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the send-side counterpart of the existing UART receiver. It serialises 8-bit bytes as 8N1 frames (or 8N2): one start bit, eight data bits LSB first, then the stop bit(s). It has a one-byte holding buffer behind a valid/ready handshake, so an upstream producer can queue the next byte while the current frame is on the wire. It sits between game/host logic and the board TX pin; its bit timing uses the same cycles-per-bit parameter as the receiver.

Parameters:
c_CYCLES_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range >= 2.
c_STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_CLK  input  1  system clock; all logic is on the rising edge.
i_RESET_N  input  1  asynchronous, active-low reset.
i_TX_DV  input  1  upstream byte valid.
i_TX_BYTE  input  8  byte to send; sampled when i_TX_DV && o_TX_READY.
o_TX_READY  output  1  holding buffer is empty and can accept a byte.
o_SERIAL_DATA  output  1  TX line, registered; idles high.
o_TX_ACTIVE  output  1  high while a frame (start, data or stop bit) is being driven.
o_TX_DONE  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (async assert, sync release): o_SERIAL_DATA=1, o_TX_ACTIVE=0, o_TX_DONE=0, o_TX_READY=1, buffer empty, FSM in IDLE, counters cleared. Asserting reset mid-frame aborts the frame at once; the line returns high and the queued byte is discarded.
- Handshake:
  - o_TX_READY is the registered inverse of buffer-full.
  - A byte is accepted on an edge where i_TX_DV && o_TX_READY; the buffer is full from that edge.
  - i_TX_DV while not ready is ignored and must not corrupt the buffer. Upstream holds the byte until it sees ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line high, o_TX_ACTIVE=0. If the buffer is full, on the next edge: load the shift register, empty the buffer, set o_SERIAL_DATA=0, set o_TX_ACTIVE=1, enter START. Latency: accept at edge E0 gives line low from edge E1.
  - START: hold 0 for c_CYCLES_PER_BIT cycles, then drive bit0 and enter DATA.
  - DATA: each bit is held for exactly c_CYCLES_PER_BIT cycles. Index runs 0..7. After bit7's period, drive 1 and enter STOP.
  - STOP: hold 1 for c_STOP_BITS*c_CYCLES_PER_BIT cycles. At the terminating edge, o_TX_DONE=1 for exactly one cycle, then:
    - buffer full: go straight to START on that same edge (line 0, no idle gap; back-to-back frames are exactly (9+c_STOP_BITS)*c_CYCLES_PER_BIT cycles apart);
    - buffer empty: go to IDLE, o_TX_ACTIVE=0.
- The buffer empties on the same edge the FSM loads the shift register. o_TX_READY rises on that edge, so a new byte can be accepted during the start bit.
- Bit counter width is $clog2(c_CYCLES_PER_BIT*c_STOP_BITS); it wraps to 0 at each bit boundary. Bit index is 3 bits.
- The FSM is fully encoded. Any unreachable state returns to IDLE with the line high.
- i_TX_BYTE is never sampled outside the accept edge.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (s_IDLE, s_START, s_DATA, s_STOP), also used by the receiver;
  - c_HIGH/c_LOW;
  - the default c_CYCLES_PER_BIT.
- One natural sub-module: uart_bit_timer. It is a loadable down-counter with a one-cycle expiry strobe, parameterised by cycle count, and can be reused by the receiver.
- Holding buffer and FSM stay in uart_tx.

Test Plan (c_CYCLES_PER_BIT=4 unless noted):
1. Reset then idle 50 cycles -> o_SERIAL_DATA=1, o_TX_READY=1, o_TX_ACTIVE=0, o_TX_DONE never pulses.
2. Send 0xA5 -> line low 1 cycle after accept, then 0 for 4 cycles, data 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. o_TX_DONE pulses once, 40 cycles after the line first falls.
3. Send 0x3C, then present 0xFF during the start bit -> 0xFF accepted, ready low until the next load. Second start bit begins on the same edge as the first o_TX_DONE. Two frames total exactly 80 cycles.
4. Hold i_TX_DV with 0x12 while ready=0, change it to 0x99 before ready rises -> only the byte present at the accept edge is transmitted; no extra frame.
5. Assert i_RESET_N low mid-DATA of 0x55 with a byte queued -> line 1 immediately, ACTIVE=0, READY=1 after release, no o_TX_DONE, no frame for the queued byte.
6. c_STOP_BITS=2, c_CYCLES_PER_BIT=434, send 0x00 -> line low for 9*434 cycles, high 868 cycles, o_TX_DONE at cycle 11*434 from the fall.
